keypad_scanner: RTL and testbench

- Upstream front end of the hangman keypad path: drives the 4x4 matrix columns, samples the raw row lines, debounces, and produces the one-hot `{row,col}` key code and single-cycle `strobe` consumed by the letter-selection FSM.
- Emits exactly one `strobe` per physical press and holds the key code as a level for the whole press.
- Key code encoding: `cur_key[7:4]` = row one-hot (R0 = bit 7 ... R3 = bit 4); `cur_key[3:0]` = column one-hot (C0 = bit 3 ... C3 = bit 0).
  - Example: R2 C0 = 8'b0010_1000.
  - Example: R3 C2 = 8'b0001_0010.

---
 rtl/keypad_scanner.sv | 152 +++++++++++++++
 tb/tb_keypad_scanner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix column scanner with row synchronizer, press/release debounce and one-shot strobe.
// Optional feature macro: KEYPAD_GHOST_REJECT_EN (reject multi-row readings instead of priority-reducing them).
module keypad_scanner #(
    parameter int unsigned SCAN_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] cur_key,
    output logic       strobe
);
    localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         row_m_q, row_m_d;
    logic [3:0]         row_s_q, row_s_d;
    logic [3:0]         col_q, col_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [DEB_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic [7:0]         cand_q, cand_d;
    logic [7:0]         cur_key_q, cur_key_d;
    logic               strobe_q, strobe_d;

    logic [3:0]         row_v;
    logic               row_ok;
    logic [3:0]         col_next;

    // Qualified row reading used for every capture and comparison
`ifdef KEYPAD_GHOST_REJECT_EN
    always_comb begin
        row_v  = row_s_q;
        row_ok = $onehot(row_s_q);
    end
`else
    always_comb begin
        row_v = 4'b0000;
        if (row_s_q[3])      row_v = 4'b1000;
        else if (row_s_q[2]) row_v = 4'b0100;
        else if (row_s_q[1]) row_v = 4'b0010;
        else if (row_s_q[0]) row_v = 4'b0001;
        row_ok = |row_s_q;
    end
`endif

    assign col_next = {col_q[0], col_q[3:1]};

    always_comb begin
        state_d    = state_q;
        row_m_d    = row_in;
        row_s_d    = row_m_q;
        col_d      = col_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        cand_d     = cand_q;
        cur_key_d  = cur_key_q;
        strobe_d   = 1'b0;

        unique case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (row_ok) begin
                        cand_d    = {row_v, col_q};
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            DEBOUNCE: begin
                // Any deviation from the candidate, including an empty or ghosted row, aborts the press
                if ({row_v, col_q} != cand_q) begin
                    state_d    = SCAN;
                    col_d      = col_next;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = HELD;
                    cur_key_d = cand_q;
                    strobe_d  = 1'b1;
                    rel_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            HELD: begin
                if (row_s_q == 4'b0000) begin
                    if (rel_cnt_q == DEB_LAST) begin
                        state_d    = SCAN;
                        cur_key_d  = 8'h00;
                        col_d      = col_next;
                        scan_cnt_d = '0;
                        deb_cnt_d  = '0;
                        rel_cnt_d  = '0;
                    end else begin
                        rel_cnt_d = rel_cnt_q + DEB_W'(1);
                    end
                end else begin
                    rel_cnt_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            row_m_q    <= 4'b0000;
            row_s_q    <= 4'b0000;
            col_q      <= 4'b1000;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            rel_cnt_q  <= '0;
            cand_q     <= 8'h00;
            cur_key_q  <= 8'h00;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_m_q    <= row_m_d;
            row_s_q    <= row_s_d;
            col_q      <= col_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            cand_q     <= cand_d;
            cur_key_q  <= cur_key_d;
            strobe_q   <= strobe_d;
        end
    end

    assign col_out = col_q;
    assign cur_key = cur_key_q;
    assign strobe  = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8 driven by a physical keypad model;
// vector table, hand-written corner sequences and a randomized press/glitch stream against a press-level model.
module tb_keypad_scanner;
    localparam int unsigned SCAN = 4;
    localparam int unsigned DEB  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [7:0] cur_key;
    logic       strobe;

    // Rows held down in each column; index 0 = C0 (col_out bit 3)
    logic [3:0] key_rows [4];

    int         total = 0;
    int         bad = 0;
    int         strobe_cnt = 0;
    logic [7:0] obs_q [$];
    logic [7:0] exp_q [$];

    typedef struct {
        int         col;
        logic [3:0] rows;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [7];

    keypad_scanner #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .row_in (row_in),
        .col_out(col_out),
        .cur_key(cur_key),
        .strobe (strobe)
    );

    always #5 clk = ~clk;

    // Matrix: a driven column lights the rows of every key held in that column
    always_comb begin
        row_in = 4'b0000;
        for (int c = 0; c < 4; c++)
            if (col_out[3-c]) row_in = row_in | key_rows[c];
    end

    always @(negedge clk) begin
        if (strobe === 1'b1) begin
            strobe_cnt++;
            obs_q.push_back(cur_key);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_key(input bit want_nonzero, input int limit, output int cycles, output bit hit);
        hit = 1'b0;
        cycles = 0;
        while (cycles < limit && !hit) begin
            @(negedge clk);
            cycles++;
            if ((cur_key != 8'h00) == want_nonzero) hit = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         cyc;
        bit         hit;
        int         s0;
        bit         col_moved;
        logic [3:0] c0;
        int         r;
        int         c;
        int         kind;
        int         nb;
        logic [7:0] rb;
        logic [7:0] cb;
        logic [7:0] code;
        logic [3:0] rowbit;

        tbl[0] = '{0, 4'b1000, 8'h88};
        tbl[1] = '{3, 4'b0001, 8'h11};
        tbl[2] = '{1, 4'b0010, 8'h24};
        tbl[3] = '{2, 4'b0100, 8'h42};
`ifdef KEYPAD_GHOST_REJECT_EN
        tbl[4] = '{1, 4'b1100, 8'h00};
        tbl[5] = '{3, 4'b0101, 8'h00};
        tbl[6] = '{0, 4'b1111, 8'h00};
`else
        tbl[4] = '{1, 4'b1100, 8'h84};
        tbl[5] = '{3, 4'b0101, 8'h41};
        tbl[6] = '{0, 4'b1111, 8'h88};
`endif

        for (int i = 0; i < 4; i++) key_rows[i] = 4'b0000;
        rst = 1'b1;
        idle(3);
        chk("reset col_out", 32'(col_out), 32'h8);
        chk("reset cur_key", 32'(cur_key), 32'h0);
        chk("reset strobe", 32'(strobe), 32'h0);

        // R2 C0 held from reset release
        key_rows[0] = 4'b0010;
        @(negedge clk);
        rst = 1'b0;
        s0 = strobe_cnt;
        wait_key(1'b1, 16, cyc, hit);
        chk("R2C0 detected within 16", 32'(hit), 32'h1);
        chk("R2C0 code", 32'(cur_key), 32'h28);
        idle(20);
        chk("R2C0 one strobe", 32'(strobe_cnt - s0), 32'h1);
        chk("R2C0 col held", 32'(col_out), 32'h8);

        // Release: accepted DEB cycles after row_s goes low (2-cycle synchronizer)
        s0 = strobe_cnt;
        key_rows[0] = 4'b0000;
        wait_key(1'b0, 40, cyc, hit);
        chk("release latency", 32'(cyc), 32'(DEB + 2));
        chk("col after release", 32'(col_out), 32'h4);
        chk("no strobe on release", 32'(strobe_cnt - s0), 32'h0);

        // R3 C2 with 3-cycle bounce
        idle(20);
        s0 = strobe_cnt;
        for (int b = 0; b < 4; b++) begin
            key_rows[2] = 4'b0001;
            idle(3);
            key_rows[2] = 4'b0000;
            idle(3);
        end
        chk("bounce no strobe", 32'(strobe_cnt - s0), 32'h0);
        chk("bounce cur_key", 32'(cur_key), 32'h0);
        key_rows[2] = 4'b0001;
        wait_key(1'b1, 60, cyc, hit);
        chk("R3C2 detected", 32'(hit), 32'h1);
        chk("R3C2 code", 32'(cur_key), 32'h12);
        idle(20);
        chk("R3C2 one strobe", 32'(strobe_cnt - s0), 32'h1);
        key_rows[2] = 4'b0000;
        wait_key(1'b0, 40, cyc, hit);
        chk("R3C2 released", 32'(hit), 32'h1);

        // 5-cycle glitch on R1 C3, aligned to the C3 dwell
        idle(10);
        s0 = strobe_cnt;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (col_out == 4'b0001) hit = 1'b1;
        end
        chk("reached C3", 32'(hit), 32'h1);
        key_rows[3] = 4'b0100;
        idle(5);
        key_rows[3] = 4'b0000;
        c0 = col_out;
        col_moved = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (col_out != c0) col_moved = 1'b1;
        end
        chk("glitch no strobe", 32'(strobe_cnt - s0), 32'h0);
        chk("glitch cur_key", 32'(cur_key), 32'h0);
        chk("glitch scan continues", 32'(col_moved), 32'h1);

        // Reset while R0 C1 is held, then re-detect
        s0 = strobe_cnt;
        key_rows[1] = 4'b1000;
        wait_key(1'b1, 60, cyc, hit);
        chk("R0C1 detected", 32'(hit), 32'h1);
        chk("R0C1 code", 32'(cur_key), 32'h84);
        idle(5);
        rst = 1'b1;
        #1;
        chk("mid-press rst cur_key", 32'(cur_key), 32'h0);
        chk("mid-press rst col_out", 32'(col_out), 32'h8);
        chk("mid-press rst strobe", 32'(strobe), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_key(1'b1, 60, cyc, hit);
        chk("R0C1 redetected", 32'(hit), 32'h1);
        chk("R0C1 recode", 32'(cur_key), 32'h84);
        idle(20);
        chk("R0C1 strobes total", 32'(strobe_cnt - s0), 32'h2);
        key_rows[1] = 4'b0000;
        wait_key(1'b0, 40, cyc, hit);
        chk("R0C1 released", 32'(hit), 32'h1);

        // Vector table: single keys and multi-row readings
        for (int i = 0; i < 7; i++) begin
            idle(20);
            s0 = strobe_cnt;
            key_rows[tbl[i].col] = tbl[i].rows;
            wait_key(1'b1, 80, cyc, hit);
            if (tbl[i].exp != 8'h00) begin
                chk($sformatf("vec%0d detect", i), 32'(hit), 32'h1);
                chk($sformatf("vec%0d code", i), 32'(cur_key), 32'(tbl[i].exp));
                idle(5);
                chk($sformatf("vec%0d one strobe", i), 32'(strobe_cnt - s0), 32'h1);
            end else begin
                chk($sformatf("vec%0d no key", i), 32'(cur_key), 32'h0);
                chk($sformatf("vec%0d no strobe", i), 32'(strobe_cnt - s0), 32'h0);
            end
            key_rows[tbl[i].col] = 4'b0000;
            wait_key(1'b0, 40, cyc, hit);
            chk($sformatf("vec%0d released", i), 32'(hit), 32'h1);
        end

        // Randomized presses and sub-debounce glitches against the press-level model
        idle(20);
        obs_q.delete();
        exp_q.delete();
        for (int n = 0; n < 24; n++) begin
            r    = int'($urandom_range(3, 0));
            c    = int'($urandom_range(3, 0));
            kind = int'($urandom_range(2, 0));
            rb   = 8'h80;
            cb   = 8'h08;
            code = (rb >> r) | (cb >> c);
            rowbit = 4'b1000 >> r;
            if (kind == 0) begin
                key_rows[c] = rowbit;
                idle(int'($urandom_range(DEB - 3, 1)));
                key_rows[c] = 4'b0000;
                idle(20);
            end else begin
                nb = int'($urandom_range(2, 0));
                for (int b = 0; b < nb; b++) begin
                    key_rows[c] = rowbit;
                    idle(int'($urandom_range(2, 1)));
                    key_rows[c] = 4'b0000;
                    idle(int'($urandom_range(2, 1)));
                end
                key_rows[c] = rowbit;
                idle(int'($urandom_range(80, 40)));
                exp_q.push_back(code);
                chk($sformatf("rand%0d held code", n), 32'(cur_key), 32'(code));
                key_rows[c] = 4'b0000;
                idle(int'($urandom_range(30, 16)));
            end
            chk($sformatf("rand%0d idle key", n), 32'(cur_key), 32'h0);
            chk($sformatf("rand%0d strobe count", n), 32'(obs_q.size()), 32'(exp_q.size()));
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("rand strobe%0d code", i), 32'(obs_q[i]), 32'(exp_q[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
